// File: rtl/nibble_add_seq_if.sv
// Operand/result bus and the external 4-bit adder link for nibble_add_seq.
// The slave modport is the sequencer's view; master is the driving side.
interface nibble_add_seq_if #(
    parameter int N_NIB = 4
);
    localparam int W = 4 * N_NIB;

    logic         START;
    logic         OP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;
    logic         COUT;
    logic         OVF;
    logic [3:0]   ADD_IN0;
    logic [3:0]   ADD_IN1;
    logic         ADD_CIN;
    logic [3:0]   ADD_SUM;
    logic         ADD_COUT;

    modport slave (
        input  START, OP, A, B, ADD_SUM, ADD_COUT,
        output BUSY, DONE, RESULT, COUT, OVF, ADD_IN0, ADD_IN1, ADD_CIN
    );

    modport master (
        output START, OP, A, B, ADD_SUM, ADD_COUT,
        input  BUSY, DONE, RESULT, COUT, OVF, ADD_IN0, ADD_IN1, ADD_CIN
    );
endinterface

// File: rtl/nibble_add_seq.sv
// Serial W-bit add/subtract built from one external 4-bit adder, one nibble
// per clock, LSB nibble first; results update only on completion.
module nibble_add_seq #(
    parameter int N_NIB = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    nibble_add_seq_if.slave    bus
);
    localparam int W  = 4 * N_NIB;
    localparam int KW = $clog2(N_NIB);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic           c_q, c_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic [KW+1:0]  base;
    logic [W-1:0]   acc_upd;
    logic           last_nib;

    // Operand signs agree but the sum's sign differs; subtract already has ~B in opB.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign base     = {k_q, 2'b00};
    assign last_nib = (k_q == KW'(N_NIB - 1));

    always_comb begin
        acc_upd            = acc_q;
        acc_upd[base +: 4] = bus.ADD_SUM;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        c_d         = c_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        bus.ADD_IN0 = 4'h0;
        bus.ADD_IN1 = 4'h0;
        bus.ADD_CIN = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    opa_d   = bus.A;
                    opb_d   = bus.OP ? ~bus.B : bus.B;
                    c_d     = bus.OP;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bus.ADD_IN0 = opa_q[base +: 4];
                bus.ADD_IN1 = opb_q[base +: 4];
                bus.ADD_CIN = c_q;
                acc_d       = acc_upd;
                c_d         = bus.ADD_COUT;
                k_d         = k_q + KW'(1);
                if (last_nib) begin
                    result_d = acc_upd;
                    cout_d   = bus.ADD_COUT;
                    ovf_d    = add_ovf(opa_q[W-1], opb_q[W-1], acc_upd[W-1]);
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            c_q      <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            c_q      <= c_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.BUSY   = (state_q != S_IDLE);
    assign bus.DONE   = (state_q == S_DONE);
    assign bus.RESULT = result_q;
    assign bus.COUT   = cout_q;
    assign bus.OVF    = ovf_q;
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 SHALL have parameter N_NIB, default 4, operand width in 4-bit nibbles (legal 2..8); W = 4*N_NIB.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port RST_N, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port START, input, 1, request to begin an operation.
REQ-005 SHALL have port OP, input, 1, 0 = add (A+B), 1 = subtract (A-B).
REQ-006 SHALL have ports A and B, input, W each, operands.
REQ-007 SHALL have port BUSY, output, 1, high in RUN and DONE states.
REQ-008 SHALL have port DONE, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port RESULT, output, W, final sum/difference.
REQ-010 SHALL have port COUT, output, 1, final carry out (for subtract, 1 = no borrow).
REQ-011 SHALL have port OVF, output, 1, signed two's-complement overflow.
REQ-012 SHALL have ports ADD_IN0 and ADD_IN1, output, 4 each, and ADD_CIN, output, 1, which drive the external 4-bit adder.
REQ-013 SHALL have ports ADD_SUM, input, 4, and ADD_COUT, input, 1, which return the external 4-bit adder result.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE with START=1 at a clock edge, the block SHALL do all of the following at that edge:
- latch A into opA;
- latch B into opB when OP=0, or ~B when OP=1;
- set carry register c to OP;
- clear nibble index k to 0;
- go to RUN.
REQ-016 In RUN, the block SHALL drive ADD_IN0 = opA[4k+3:4k], ADD_IN1 = opB[4k+3:4k] and ADD_CIN = c combinationally from registers.
REQ-017 At each RUN edge, the block SHALL do all of the following:
- store ADD_SUM into accumulator nibble k;
- set c to ADD_COUT;
- increment k.
REQ-018 At the RUN edge where k = N_NIB-1, the block SHALL do all of the following:
- load RESULT with the full accumulator, including the nibble captured at that edge;
- load COUT with ADD_COUT;
- load OVF with (opA[W-1] == opB[W-1]) && (result[W-1] != opA[W-1]);
- go to DONE.
REQ-019 The DONE state SHALL last exactly one cycle with DONE=1, then go to IDLE unconditionally.
REQ-020 Latency: START accepted at edge 0 -> nibbles captured at edges 1..N_NIB -> DONE high during the cycle after edge N_NIB; one operation per N_NIB+2 cycles when START is held high.
REQ-021 START SHALL be ignored while BUSY=1; A, B and OP changes after acceptance SHALL not affect the operation in flight.
REQ-022 RESULT, COUT and OVF SHALL hold their values from DONE until the next completion; they SHALL never show partial results.
REQ-023 Outside RUN, ADD_IN0, ADD_IN1 and ADD_CIN SHALL be driven to 0.
REQ-024 Sum arithmetic SHALL be modulo 2^W; the carry out of the top nibble SHALL appear only on COUT.

Reset
REQ-025 While RST_N=0, the block SHALL immediately, without waiting for a clock edge, force the following to 0:
- state = IDLE and k;
- c, opA, opB and the accumulator;
- RESULT, COUT, OVF, DONE and BUSY;
- ADD_IN0, ADD_IN1 and ADD_CIN.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse; the first START after RST_N returns high SHALL be processed normally.

Verification
REQ-027 Scenario 1, N_NIB=4, OP=0, A=0x1234, B=0x0FFF, START at edge 0 -> DONE high after edge 4; RESULT=0x2233, COUT=0, OVF=0.
REQ-028 Scenario 2, carry and wrap-around:
- OP=0, A=0xFFFF, B=0x0001 -> RESULT=0x0000, COUT=1, OVF=0;
- OP=0, A=0x7FFF, B=0x0001 -> RESULT=0x8000, COUT=0, OVF=1.
REQ-029 Scenario 3, subtract:
- OP=1, A=0x0005, B=0x0007 -> RESULT=0xFFFE, COUT=0, OVF=0;
- OP=1, A=0x8000, B=0x0001 -> RESULT=0x7FFF, COUT=1, OVF=1.
REQ-030 Scenario 4, START pulsed again during RUN with A=0xAAAA and OP changed -> ignored; RESULT matches the originally accepted operands; exactly one DONE pulse.
REQ-031 Scenario 5, RST_N pulled low asynchronously between edges 2 and 3 of an add -> all outputs 0 immediately, no DONE; then 0x0001+0x0002 -> RESULT=0x0003.
REQ-032 Scenario 6, START held high continuously with fixed operands -> DONE pulses exactly every 6 cycles; ADD_IN0/ADD_IN1/ADD_CIN are 0 in the IDLE and DONE cycles.
